line_raster_engine: RTL

Parametrised all-octant Bresenham line rasteriser for the HDL graphics processor. It accepts two endpoints per command and emits one pixel coordinate per cycle on a valid/ready stream. The stream feeds the framebuffer write arbiter, alongside the triangle/fill engines. Compared with the previous single-octant line block, it adds:
- any slope and direction,
- configurable coordinate widths,
- output backpressure,
- a start/busy/done command handshake,
- asynchronous reset.

---
 rtl/gfx_raster_pkg.sv | 19 +
 rtl/line_setup_calc.sv | 35 +++
 rtl/line_raster_engine.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/gfx_raster_pkg.sv
// Shared types and width helpers for the raster engines.
package gfx_raster_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    DRAW   = 2'd2,
    FINISH = 2'd3
  } raster_state_t;

  localparam int SCREEN_XW = 10;
  localparam int SCREEN_YW = 9;

  // Signed working width: one bit of headroom for 2*err and one for the sign.
  function automatic int calc_w(input int xw, input int yw);
    return ((xw > yw) ? xw : yw) + 2;
  endfunction

endpackage

// File: rtl/line_setup_calc.sv
// Combinational Bresenham setup: endpoint deltas, step directions and the
// initial error term. Shared with the triangle edge walker.
module line_setup_calc
  import gfx_raster_pkg::*;
#(
  parameter int XW = SCREEN_XW,
  parameter int YW = SCREEN_YW,
  parameter int W  = calc_w(XW, YW)
) (
  input  logic [XW-1:0]       x0,
  input  logic [YW-1:0]       y0,
  input  logic [XW-1:0]       x1,
  input  logic [YW-1:0]       y1,
  output logic signed [W-1:0] dx,
  output logic signed [W-1:0] dy,
  output logic signed [W-1:0] err0,
  output logic                sx_neg,
  output logic                sy_neg
);

  logic signed [W-1:0] diff_x;
  logic signed [W-1:0] diff_y;

  // Zero-extend into the signed width, take signed differences, then magnitudes.
  always_comb begin
    diff_x = $signed(W'(x1)) - $signed(W'(x0));
    diff_y = $signed(W'(y1)) - $signed(W'(y0));
    sx_neg = diff_x[W-1];
    sy_neg = diff_y[W-1];
    dx     = sx_neg ? -diff_x : diff_x;
    dy     = sy_neg ? -diff_y : diff_y;
    err0   = dx - dy;
  end

endmodule

// File: rtl/line_raster_engine.sv
// All-octant Bresenham line rasteriser with a valid/ready pixel stream and a
// start/busy/done command handshake.
module line_raster_engine
  import gfx_raster_pkg::*;
#(
  parameter int XW = SCREEN_XW,
  parameter int YW = SCREEN_YW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y1,
  output logic          busy,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          pix_last,
  output logic          done
);

  localparam int W = calc_w(XW, YW);

  raster_state_t state_reg, state_next;

  // Command endpoints, frozen for the whole line.
  logic [XW-1:0] x0_reg, x1_reg;
  logic [YW-1:0] y0_reg, y1_reg;

  // Stepping datapath.
  logic signed [W-1:0] dx_reg, dy_reg, err_reg;
  logic                sx_neg_reg, sy_neg_reg;
  logic [XW-1:0]       cur_x_reg;
  logic [YW-1:0]       cur_y_reg;

  logic pix_valid_reg, pix_last_reg, busy_reg, done_reg;

  // Setup results and next-step values.
  logic signed [W-1:0] calc_dx, calc_dy, calc_err0;
  logic                calc_sx_neg, calc_sy_neg;
  logic signed [W-1:0] e2, err_next;
  logic                step_x, step_y;
  logic [XW-1:0]       cur_x_next;
  logic [YW-1:0]       cur_y_next;
  logic                last_next;
  logic                fire;

  line_setup_calc #(
    .XW(XW),
    .YW(YW),
    .W (W)
  ) u_setup (
    .x0    (x0_reg),
    .y0    (y0_reg),
    .x1    (x1_reg),
    .y1    (y1_reg),
    .dx    (calc_dx),
    .dy    (calc_dy),
    .err0  (calc_err0),
    .sx_neg(calc_sx_neg),
    .sy_neg(calc_sy_neg)
  );

  assign fire = pix_valid_reg & pix_ready;

  // One Bresenham step from the current pixel; both axis decisions use the old err.
  always_comb begin
    e2         = err_reg <<< 1;
    step_x     = (e2 > -dy_reg);
    step_y     = (e2 < dx_reg);
    err_next   = err_reg;
    cur_x_next = cur_x_reg;
    cur_y_next = cur_y_reg;
    if (step_x) begin
      err_next   = err_next - dy_reg;
      cur_x_next = sx_neg_reg ? (cur_x_reg - XW'(1)) : (cur_x_reg + XW'(1));
    end
    if (step_y) begin
      err_next   = err_next + dx_reg;
      cur_y_next = sy_neg_reg ? (cur_y_reg - YW'(1)) : (cur_y_reg + YW'(1));
    end
    last_next = (cur_x_next == x1_reg) && (cur_y_next == y1_reg);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode; backpressure only holds the FSM in DRAW.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SETUP;
      SETUP:   state_next = DRAW;
      DRAW:    if (fire && pix_last_reg) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Endpoint latch, stepping registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0_reg        <= '0;
      y0_reg        <= '0;
      x1_reg        <= '0;
      y1_reg        <= '0;
      dx_reg        <= '0;
      dy_reg        <= '0;
      err_reg       <= '0;
      sx_neg_reg    <= 1'b0;
      sy_neg_reg    <= 1'b0;
      cur_x_reg     <= '0;
      cur_y_reg     <= '0;
      pix_valid_reg <= 1'b0;
      pix_last_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            x0_reg   <= x0;
            y0_reg   <= y0;
            x1_reg   <= x1;
            y1_reg   <= y1;
            busy_reg <= 1'b1;
          end
        end
        SETUP: begin
          dx_reg        <= calc_dx;
          dy_reg        <= calc_dy;
          err_reg       <= calc_err0;
          sx_neg_reg    <= calc_sx_neg;
          sy_neg_reg    <= calc_sy_neg;
          cur_x_reg     <= x0_reg;
          cur_y_reg     <= y0_reg;
          pix_valid_reg <= 1'b1;
          pix_last_reg  <= (x0_reg == x1_reg) && (y0_reg == y1_reg);
        end
        DRAW: begin
          if (fire) begin
            if (pix_last_reg) begin
              pix_valid_reg <= 1'b0;
              pix_last_reg  <= 1'b0;
              busy_reg      <= 1'b0;
              done_reg      <= 1'b1;
            end else begin
              err_reg      <= err_next;
              cur_x_reg    <= cur_x_next;
              cur_y_reg    <= cur_y_next;
              pix_last_reg <= last_next;
            end
          end
        end
        FINISH: begin
          done_reg <= 1'b0;
        end
        default: begin
          done_reg <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_reg;
  assign pix_valid = pix_valid_reg;
  assign pix_x     = cur_x_reg;
  assign pix_y     = cur_y_reg;
  assign pix_last  = pix_last_reg;
  assign done      = done_reg;

endmodule
